// File: rtl/layer_result_sequencer_if.sv
// Handshake and result bus between the layer sequencer, the neuron processing
// unit and the next layer. The sequencer is the slave side.
interface layer_result_sequencer_if #(
    parameter int SEL_W   = 4,
    parameter int VEC_LEN = 62
);
    logic                   go;
    logic                   pu_ready;
    logic [7:0]             pu_out;
    logic                   pu_start;
    logic [SEL_W-1:0]       neuron_sel;
    logic [VEC_LEN*8-1:0]   layer_vec;
    logic [7:0]             max_value;
    logic [SEL_W-1:0]       max_index;
    logic                   layer_done;

    modport master (
        output go, pu_ready, pu_out,
        input  pu_start, neuron_sel, layer_vec, max_value, max_index, layer_done
    );

    modport slave (
        input  go, pu_ready, pu_out,
        output pu_start, neuron_sel, layer_vec, max_value, max_index, layer_done
    );
endinterface

// File: rtl/layer_result_sequencer.sv
// Runs one MLP layer neuron by neuron: starts the processing unit, captures each
// signed byte result into the packed layer vector and tracks the running argmax.
module layer_result_sequencer #(
    parameter int NUM_NEURONS = 10,
    parameter int VEC_LEN     = 62,
    parameter int SEL_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_result_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_NEURONS - 1);

    state_t                 state;
    logic                   ready_d;
    logic [7:0]             slots [NUM_NEURONS];
    logic signed [7:0]      max_q;
    logic [SEL_W-1:0]       sel_q;
    logic [SEL_W-1:0]       max_idx_q;
    logic                   start_q;
    logic                   done_q;
    logic                   ready_edge;
    logic                   take_max;

    // A ready level that persists across neurons must not be captured twice.
    assign ready_edge = bus.pu_ready & ~ready_d;
    assign take_max   = (sel_q == '0) || ($signed(bus.pu_out) > max_q);

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ready_d   <= 1'b1;
            sel_q     <= '0;
            max_q     <= 8'h80;
            max_idx_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: the slot array is small and its cleared value is visible on
            // layer_vec, so it is reset like ordinary flops rather than left as RAM.
            for (int i = 0; i < NUM_NEURONS; i++) slots[i] <= 8'h00;
        end else begin
            ready_d <= bus.pu_ready;
            start_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        for (int i = 0; i < NUM_NEURONS; i++) slots[i] <= 8'h00;
                        sel_q     <= '0;
                        max_q     <= 8'h80;
                        max_idx_q <= '0;
                        done_q    <= 1'b0;
                        start_q   <= 1'b1;
                        state     <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (ready_edge) begin
                        slots[sel_q] <= bus.pu_out;
                        if (take_max) begin
                            max_q     <= bus.pu_out;
                            max_idx_q <= sel_q;
                        end
                        if (sel_q == LAST_SEL) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            sel_q   <= sel_q + SEL_W'(1);
                            start_q <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_pack
        if (i < NUM_NEURONS) begin : g_live
            assign bus.layer_vec[8*i +: 8] = slots[i];
        end else begin : g_zero
            assign bus.layer_vec[8*i +: 8] = 8'h00;
        end
    end

    assign bus.pu_start   = start_q;
    assign bus.layer_done = done_q;
    assign bus.neuron_sel = sel_q;
    assign bus.max_value  = max_q;
    assign bus.max_index  = max_idx_q;
endmodule

// File: tb/tb_layer_result_sequencer.sv
// Directed bench for layer_result_sequencer: a transaction-level layer model is
// compared every cycle, plus hand-computed literals at key points.
module tb_layer_result_sequencer;
    localparam int NN = 10;
    localparam int VL = 62;
    localparam int SW = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   start_cnt;
    int   consumed;

    layer_result_sequencer_if #(.SEL_W(SW), .VEC_LEN(VL)) bus ();

    layer_result_sequencer #(.NUM_NEURONS(NN), .VEC_LEN(VL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: captured results of the current layer ----------------
    logic [7:0] m_slot [VL];
    int         m_ncap;
    bit         m_active;
    bit         m_pulse;
    bit         m_done;
    bit         m_rdy_prev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active   <= 1'b0;
            m_pulse    <= 1'b0;
            m_done     <= 1'b0;
            m_ncap     <= 0;
            m_rdy_prev <= 1'b1;
            for (int i = 0; i < VL; i++) m_slot[i] <= 8'h00;
        end else begin
            m_rdy_prev <= bus.pu_ready;
            if (!m_active) begin
                if (bus.go) begin
                    for (int i = 0; i < VL; i++) m_slot[i] <= 8'h00;
                    m_ncap   <= 0;
                    m_active <= 1'b1;
                    m_pulse  <= 1'b1;
                    m_done   <= 1'b0;
                end
            end else if (m_pulse) begin
                m_pulse <= 1'b0;
            end else if (bus.pu_ready && !m_rdy_prev) begin
                m_slot[m_ncap] <= bus.pu_out;
                m_ncap         <= m_ncap + 1;
                if (m_ncap == NN - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_pulse <= 1'b1;
                end
            end
        end
    end

    function automatic logic [SW-1:0] exp_sel();
        return SW'((m_ncap == NN) ? NN - 1 : m_ncap);
    endfunction

    function automatic logic [7:0] exp_max();
        int best;
        best = -128;
        for (int i = 0; i < m_ncap; i++)
            if (int'($signed(m_slot[i])) > best) best = int'($signed(m_slot[i]));
        return 8'(best);
    endfunction

    function automatic logic [SW-1:0] exp_idx();
        logic [7:0] mx;
        mx = exp_max();
        for (int i = 0; i < m_ncap; i++)
            if (m_slot[i] == mx) return SW'(i);
        return '0;
    endfunction

    function automatic logic [VL*8-1:0] exp_vec();
        logic [VL*8-1:0] v;
        for (int i = 0; i < VL; i++) v[8*i +: 8] = m_slot[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("pu_start",   512'(bus.pu_start),   512'(m_pulse));
        check("layer_done", 512'(bus.layer_done), 512'(m_done));
        check("neuron_sel", 512'(bus.neuron_sel), 512'(exp_sel()));
        check("layer_vec",  512'(bus.layer_vec),  512'(exp_vec()));
        check("max_value",  512'(bus.max_value),  512'(exp_max()));
        check("max_index",  512'(bus.max_index),  512'(exp_idx()));
    end

    always @(negedge clk) if (bus.pu_start) start_cnt <= start_cnt + 1;

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_go();
        step();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
    endtask

    task automatic do_reset();
        bus.go       = 1'b0;
        bus.pu_ready = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        consumed = start_cnt;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (start_cnt <= consumed && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("start_timeout", 512'(start_cnt > consumed), 512'(1));
        consumed++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.layer_done && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", 512'(bus.layer_done), 512'(1));
    endtask

    task automatic respond(input logic [7:0] v, input int lat, input int hold);
        wait_start();
        repeat (lat) step();
        bus.pu_out   = v;
        bus.pu_ready = 1'b1;
        repeat (hold) step();
        bus.pu_ready = 1'b0;
    endtask

    task automatic run_layer(input logic [7:0] v [NN], input int lat, input bit alt_hold);
        for (int i = 0; i < NN; i++) respond(v[i], lat, alt_hold ? 2 + (i % 2) : 1);
        wait_done();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] vals [NN];
        int base;
        n_chk = 0;
        n_err = 0;
        start_cnt = 0;
        consumed = 0;
        rst = 1'b0;
        bus.go = 1'b1;
        bus.pu_ready = 1'b1;
        bus.pu_out = 8'h00;

        // Reset held with go and ready high, released with go low, ready stays high.
        repeat (3) step();
        rst = 1'b1;
        bus.go = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("rst_pu_start",  512'(bus.pu_start),  512'(0));
        check("rst_max_value", 512'(bus.max_value), 512'(8'h80));
        check("rst_vec",       512'(bus.layer_vec), 512'(0));
        pulse_go();
        repeat (5) step();
        check("stuck_ready_sel", 512'(bus.neuron_sel), 512'(0));
        check("stuck_ready_vec", 512'(bus.layer_vec),  512'(0));
        bus.pu_ready = 1'b0;
        step();
        step();
        bus.pu_out = 8'h33;
        bus.pu_ready = 1'b1;
        step();
        bus.pu_ready = 1'b0;
        @(negedge clk);
        check("first_capture_slot0", 512'(bus.layer_vec[7:0]), 512'(8'h33));
        check("first_capture_sel",   512'(bus.neuron_sel),      512'(1));
        do_reset();

        // Full layer with 3-cycle latency.
        vals = '{8'h05, 8'hFD, 8'h14, 8'h14, 8'h07, 8'h80, 8'h00, 8'h13, 8'h01, 8'h02};
        base = start_cnt;
        pulse_go();
        run_layer(vals, 3, 1'b0);
        check("full_vec", 512'(bus.layer_vec),
              512'({416'h0, 8'h02, 8'h01, 8'h13, 8'h00, 8'h80, 8'h07, 8'h14, 8'h14, 8'hFD, 8'h05}));
        check("full_max_value",  512'(bus.max_value),   512'(8'd20));
        check("full_max_index",  512'(bus.max_index),   512'(2));
        check("full_start_count", 512'(start_cnt - base), 512'(10));

        // Ready held high into the next START, alternating hold lengths.
        vals = '{8'h03, 8'h09, 8'hFF, 8'h09, 8'h0C, 8'h0C, 8'hFB, 8'h00, 8'h01, 8'h0C};
        base = start_cnt;
        pulse_go();
        run_layer(vals, 2, 1'b1);
        check("hold_max_value",  512'(bus.max_value),   512'(8'h0C));
        check("hold_max_index",  512'(bus.max_index),   512'(4));
        check("hold_sel",        512'(bus.neuron_sel),  512'(9));
        check("hold_slot9",      512'(bus.layer_vec[79:72]), 512'(8'h0C));
        check("hold_start_count", 512'(start_cnt - base), 512'(10));

        // All results at the minimum value.
        vals = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        pulse_go();
        run_layer(vals, 1, 1'b0);
        check("min_max_value", 512'(bus.max_value),       512'(8'h80));
        check("min_max_index", 512'(bus.max_index),       512'(0));
        check("min_vec",       512'(bus.layer_vec[79:0]), 512'({10{8'h80}}));

        // All-negative results with a tie at the max.
        vals = '{8'hF7, 8'hFE, 8'hFE, 8'hCE, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        pulse_go();
        run_layer(vals, 2, 1'b0);
        check("neg_max_value", 512'(bus.max_value), 512'(8'hFE));
        check("neg_max_index", 512'(bus.max_index), 512'(1));

        // Reset after four captures, with a go pulse ignored in WAIT first.
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h08, 8'h09, 8'h0A};
        pulse_go();
        for (int i = 0; i < 4; i++) respond(vals[i], 2, 1);
        wait_start();
        step();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("abort_pu_start",   512'(bus.pu_start),   512'(0));
        check("abort_layer_done", 512'(bus.layer_done), 512'(0));
        check("abort_vec",        512'(bus.layer_vec),  512'(0));
        check("abort_sel",        512'(bus.neuron_sel), 512'(0));
        check("abort_max_value",  512'(bus.max_value),  512'(8'h80));
        step();
        rst = 1'b1;
        consumed = start_cnt;
        repeat (3) step();
        check("abort_idle_start", 512'(bus.pu_start), 512'(0));
        pulse_go();
        @(negedge clk);
        check("restart_sel",   512'(bus.neuron_sel), 512'(0));
        check("restart_start", 512'(bus.pu_start),   512'(1));
        run_layer(vals, 2, 1'b0);
        check("restart_max_index", 512'(bus.max_index), 512'(6));

        // In DONE: go together with a pu_ready rise; restart wins.
        step();
        bus.go = 1'b1;
        bus.pu_out = 8'h55;
        bus.pu_ready = 1'b1;
        step();
        bus.go = 1'b0;
        @(negedge clk);
        check("done_go_start", 512'(bus.pu_start),   512'(1));
        check("done_go_vec",   512'(bus.layer_vec),  512'(0));
        check("done_go_max",   512'(bus.max_value),  512'(8'h80));
        check("done_go_done",  512'(bus.layer_done), 512'(0));
        step();
        step();
        bus.pu_ready = 1'b0;
        vals = '{8'h21, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        run_layer(vals, 2, 1'b0);
        check("done_go_slot0", 512'(bus.layer_vec[7:0]), 512'(8'h21));

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end
endmodule
